// File: rtl/led_sequencer.sv
// led_sequencer
//
// Purpose: CPU-programmable LED pattern sequencer. The CPU side is a small
// register file (CTRL, STATUS, PRESCALE, ENTRY[0..7]) reached through a
// Write/Read/Ack 4-way handshake. Once enabled, the FSM steps through
// ENTRY[0..last], pushing each 14-bit pattern (plus the irq_mode flag) to
// the LED peripheral with a led_Write/led_Ack 4-way handshake, then waits
// dwell x (PRESCALE+1) clocks before moving on.
//
// Ports:
//   clock       in   1   single clock, rising edge
//   reset       in   1   synchronous, active-high
//   address     in   4   register select
//   dataIn      in  32   CPU write data
//   Write/Read  in   1   CPU handshake requests
//   dataOut     out 32   combinational read data for the addressed register
//   Ack         out  1   CPU handshake acknowledge (Write|Read delayed 1 cycle)
//   led_dataIn  out 15   {irq_mode, pattern} sent to the LED peripheral
//   led_Write   out  1   LED-side write request
//   led_Ack     in   1   LED-side acknowledge

module led_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic [31:0] dataIn,
    input  logic        Write,
    input  logic        Read,
    output logic [31:0] dataOut,
    output logic        Ack,
    output logic [14:0] led_dataIn,
    output logic        led_Write,
    input  logic        led_Ack
);

    typedef enum logic [2:0] {IDLE, LOAD, WREQ, WREL, DWELL} state_t;

    state_t      state;

    logic        enable;
    logic        loop_en;
    logic        irq_mode;
    logic [2:0]  last_index;
    logic [15:0] prescale;
    logic [13:0] entry_pattern [8];
    logic [15:0] entry_dwell   [8];

    logic        busy;
    logic        done;
    logic [2:0]  index;
    logic [15:0] work_dwell;
    logic [15:0] pre_reload;
    logic [15:0] pre_count;
    logic [15:0] dwell_count;

    logic        ctrl_write;
    logic        enable_next;

    // A CTRL write in the same cycle takes effect immediately for abort
    // decisions, so the FSM looks at the enable value being written.
    assign ctrl_write  = Write && (address == 4'h0);
    assign enable_next = ctrl_write ? dataIn[0] : enable;

    // CPU-side register file and handshake acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            Ack        <= 1'b0;
            enable     <= 1'b0;
            loop_en    <= 1'b0;
            irq_mode   <= 1'b0;
            last_index <= 3'd0;
            prescale   <= 16'd0;
            for (int i = 0; i < 8; i++) begin
                entry_pattern[i] <= 14'd0;
                entry_dwell[i]   <= 16'd0;
            end
        end else begin
            Ack <= Write | Read;
            if (Write) begin
                if (address == 4'h0) begin
                    enable     <= dataIn[0];
                    loop_en    <= dataIn[1];
                    irq_mode   <= dataIn[2];
                    last_index <= dataIn[6:4];
                end else if (address == 4'h2) begin
                    prescale <= dataIn[15:0];
                end else if (address[3]) begin
                    entry_pattern[address[2:0]] <= dataIn[13:0];
                    entry_dwell[address[2:0]]   <= dataIn[31:16];
                end
            end
        end
    end

    // Read mux; unmapped addresses and unused bits read as zero.
    always_comb begin
        dataOut = 32'd0;
        if (address[3]) begin
            dataOut = {entry_dwell[address[2:0]], 2'b00, entry_pattern[address[2:0]]};
        end else begin
            case (address[2:0])
                3'h0:    dataOut = {25'd0, last_index, 1'b0, irq_mode, loop_en, enable};
                3'h1:    dataOut = {25'd0, index, 2'b00, done, busy};
                3'h2:    dataOut = {16'd0, prescale};
                default: dataOut = 32'd0;
            endcase
        end
    end

    // Sequencer FSM. led_dataIn doubles as the working pattern register: it
    // is only loaded in LOAD, so it stays stable across the whole handshake
    // even if the displayed ENTRY is rewritten. The prescale value is latched
    // on DWELL entry so a mid-dwell PRESCALE write only affects later dwells.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            index       <= 3'd0;
            work_dwell  <= 16'd0;
            pre_reload  <= 16'd0;
            pre_count   <= 16'd0;
            dwell_count <= 16'd0;
            led_dataIn  <= 15'd0;
            led_Write   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_write && dataIn[0] && !enable) begin
                        state <= LOAD;
                        index <= 3'd0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!enable_next) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        work_dwell <= (entry_dwell[index] == 16'd0) ? 16'd1 : entry_dwell[index];
                        led_dataIn <= {irq_mode, entry_pattern[index]};
                        led_Write  <= 1'b1;
                        state      <= WREQ;
                    end
                end
                WREQ: begin
                    if (led_Ack) begin
                        led_Write <= 1'b0;
                        state     <= WREL;
                    end
                end
                WREL: begin
                    if (!led_Ack) begin
                        if (!enable_next) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state       <= DWELL;
                            pre_reload  <= prescale;
                            pre_count   <= prescale;
                            dwell_count <= work_dwell;
                        end
                    end
                end
                DWELL: begin
                    if (!enable_next) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (pre_count == 16'd0) begin
                        pre_count <= pre_reload;
                        if (dwell_count == 16'd1) begin
                            if (index < last_index) begin
                                index <= index + 3'd1;
                                state <= LOAD;
                            end else if (loop_en) begin
                                index <= 3'd0;
                                state <= LOAD;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            dwell_count <= dwell_count - 16'd1;
                        end
                    end else begin
                        pre_count <= pre_count - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
